rfft_pingpong_buffer: RTL and testbench

Parametrised two-bank frame buffer that sits between the host I/O and the rfft core. It generalises the single-frame Din0..3/Dout0..3/Addr interface to LANES lanes of WIDTH bits and POINTS points. Loading of frame N+1 overlaps with processing and draining of frame N. The core reads and writes its operands in place through a dedicated port.

---
 rtl/rfft_pkg.sv | 27 ++
 rtl/rfft_bank_ram.sv | 39 +++
 rtl/rfft_pingpong_buffer.sv | 193 +++++++++++++++++++
 tb/tb_rfft_pingpong_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfft_pkg.sv
// Shared types and defaults for the rfft ping-pong frame buffer.
// RFFT_BITREV_EN (see top) is the only build option that uses bitrev().
package rfft_pkg;

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        LOADING = 3'd1,
        FULL    = 3'd2,
        PROC    = 3'd3,
        DRAIN   = 3'd4
    } bank_state_e;

    localparam int RFFT_WIDTH  = 32;
    localparam int RFFT_LANES  = 4;
    localparam int RFFT_POINTS = 256;

    // Reverse the low n bits of v.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < n; i++) begin
            r = (r << 1) | ((v >> i) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/rfft_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port and one registered,
// read-first read port whose output register holds when not reading.
module rfft_bank_ram
    import rfft_pkg::*;
#(
    parameter int DW = 128,
    parameter int AW = 6
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rd_data;

    // Contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rfft_pingpong_buffer.sv
// Two-bank ping-pong frame buffer between host load/drain streams and the rfft core.
// Define RFFT_BITREV_EN to drain lane-words in bit-reversed address order.
module rfft_pingpong_buffer
    import rfft_pkg::*;
#(
    parameter  int WIDTH  = RFFT_WIDTH,
    parameter  int LANES  = RFFT_LANES,
    parameter  int POINTS = RFFT_POINTS,
    localparam int DEPTH  = POINTS / LANES,
    localparam int AW     = $clog2(DEPTH),
    localparam int DW     = LANES * WIDTH
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          frame_ready,
    input  logic          core_start,
    input  logic          core_rd_en,
    input  logic [AW-1:0] core_rd_addr,
    output logic [DW-1:0] core_rd_data,
    input  logic          core_wr_en,
    input  logic [AW-1:0] core_wr_addr,
    input  logic [DW-1:0] core_wr_data,
    input  logic          core_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          err_overrun,
    output logic          err_len
);

    // Every stream is a valid/ready handshake: a beat transfers on a rising
    // edge where both are high; the sender holds its payload until then.

    bank_state_e   r_st [2];
    bank_state_e   w_st_nxt [2];
    logic          r_load_ptr, r_serve_ptr, r_drain_ptr;
    logic          w_in_acc, w_proc_any, w_proc_bank, w_start;
    logic          w_dr_busy, w_dr_rd, w_dr_done;
    logic [AW-1:0] r_idx, r_out_idx, w_dr_ram_addr;
    logic          r_issue_pend, r_out_valid;
    logic          r_core_rd_d, r_core_bank;
    logic [DW-1:0] r_core_hold;
    logic          r_err_overrun, r_err_len;
    logic [DW-1:0] w_ram_rd [2];

    assign in_ready    = (r_st[r_load_ptr] == EMPTY) || (r_st[r_load_ptr] == LOADING);
    assign w_in_acc    = in_valid && in_ready;
    assign w_proc_any  = (r_st[0] == PROC) || (r_st[1] == PROC);
    assign w_proc_bank = (r_st[1] == PROC);
    // Frames are loaded, served and drained in strict alternation, so the
    // serve pointer always names the older FULL bank.
    assign frame_ready = (r_st[r_serve_ptr] == FULL) && !w_proc_any;
    assign w_start     = core_start && frame_ready;

    assign w_dr_busy = (r_st[r_drain_ptr] == DRAIN);
    assign w_dr_rd   = w_dr_busy && r_issue_pend && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign out_last  = r_out_valid && (r_out_idx == AW'(DEPTH - 1));
    assign w_dr_done = r_out_valid && out_ready && out_last;

`ifdef RFFT_BITREV_EN
    assign w_dr_ram_addr = AW'(bitrev(32'(r_idx), AW));
    assign out_addr      = AW'(bitrev(32'(r_out_idx), AW));
`else
    assign w_dr_ram_addr = r_idx;
    assign out_addr      = r_out_idx;
`endif

    // Per-bank lifecycle; each event targets a bank in a distinct state.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_st_nxt[b] = r_st[b];
            case (r_st[b])
                EMPTY:   if (w_in_acc && (r_load_ptr == 1'(b)))
                             w_st_nxt[b] = in_last ? FULL : LOADING;
                LOADING: if (w_in_acc && (r_load_ptr == 1'(b)) && in_last)
                             w_st_nxt[b] = FULL;
                FULL:    if (w_start && (r_serve_ptr == 1'(b)))
                             w_st_nxt[b] = PROC;
                PROC:    if (core_done)
                             w_st_nxt[b] = DRAIN;
                DRAIN:   if (w_dr_done && (r_drain_ptr == 1'(b)))
                             w_st_nxt[b] = EMPTY;
                default: w_st_nxt[b] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_st[0]     <= EMPTY;
            r_st[1]     <= EMPTY;
            r_load_ptr  <= 1'b0;
            r_serve_ptr <= 1'b0;
            r_drain_ptr <= 1'b0;
        end else begin
            r_st[0] <= w_st_nxt[0];
            r_st[1] <= w_st_nxt[1];
            if (w_in_acc && in_last) r_load_ptr  <= !r_load_ptr;
            if (w_start)             r_serve_ptr <= !r_serve_ptr;
            if (w_dr_done)           r_drain_ptr <= !r_drain_ptr;
        end
    end

    // Drainer: one read in flight ahead of the presented beat.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx        <= '0;
            r_out_idx    <= '0;
            r_issue_pend <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_dr_rd) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= r_idx;
                r_idx       <= r_idx + 1'b1;
                if (r_idx == AW'(DEPTH - 1)) r_issue_pend <= 1'b0;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_dr_done) begin
                r_issue_pend <= 1'b1;
                r_idx        <= '0;
            end
        end
    end

    // Core read data is live the cycle after a read, then held locally so a
    // later drain of the same bank cannot disturb it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_core_rd_d <= 1'b0;
            r_core_bank <= 1'b0;
            r_core_hold <= '0;
        end else begin
            r_core_rd_d <= core_rd_en && w_proc_any;
            if (core_rd_en && w_proc_any) r_core_bank <= w_proc_bank;
            r_core_hold <= core_rd_data;
        end
    end

    assign core_rd_data = r_core_rd_d ? w_ram_rd[r_core_bank] : r_core_hold;
    assign out_data     = w_ram_rd[r_drain_ptr];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_err_overrun <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            if (in_valid && !in_ready) r_err_overrun <= 1'b1;
            if (w_in_acc && in_last && (in_addr != AW'(DEPTH - 1))) r_err_len <= 1'b1;
        end
    end

    assign err_overrun = r_err_overrun;
    assign err_len     = r_err_len;

    // Bank ports are steered purely by bank state: one owner per state.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic          w_is_proc, w_we, w_re;
        logic [AW-1:0] w_wa, w_ra;
        logic [DW-1:0] w_wd;

        assign w_is_proc = (r_st[g] == PROC);
        assign w_we = (w_in_acc && (r_load_ptr == 1'(g))) || (core_wr_en && w_is_proc);
        assign w_wa = w_is_proc ? core_wr_addr : in_addr;
        assign w_wd = w_is_proc ? core_wr_data : in_data;
        assign w_re = (core_rd_en && w_is_proc) || (w_dr_rd && (r_drain_ptr == 1'(g)));
        assign w_ra = w_is_proc ? core_rd_addr : w_dr_ram_addr;

        rfft_bank_ram #(
            .DW (DW),
            .AW (AW)
        ) u_ram (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .i_wr_en   (w_we),
            .i_wr_addr (w_wa),
            .i_wr_data (w_wd),
            .i_rd_en   (w_re),
            .i_rd_addr (w_ra),
            .o_rd_data (w_ram_rd[g])
        );
    end

endmodule

// File: tb/tb_rfft_pingpong_buffer.sv
// Directed bench for rfft_pingpong_buffer: load/process/drain scenarios with
// hand-derived expectations; honours RFFT_BITREV_EN for the drain order.
module tb_rfft_pingpong_buffer;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int POINTS = 256;
    localparam int DEPTH = 64;
    localparam int AW = 6;
    localparam int DW = 128;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          frame_ready;
    logic          core_start = 1'b0;
    logic          core_rd_en = 1'b0;
    logic [AW-1:0] core_rd_addr = '0;
    logic [DW-1:0] core_rd_data;
    logic          core_wr_en = 1'b0;
    logic [AW-1:0] core_wr_addr = '0;
    logic [DW-1:0] core_wr_data = '0;
    logic          core_done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err_overrun;
    logic          err_len;

    int checks = 0;
    int errors = 0;

    int            n_beats, n_last, last_pos, stall_bad;
    bit            timed_out;
    logic [AW-1:0] got_addr [DEPTH];
    logic [DW-1:0] got_data [DEPTH];

    rfft_pingpong_buffer #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .POINTS (POINTS)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_last      (in_last),
        .frame_ready  (frame_ready),
        .core_start   (core_start),
        .core_rd_en   (core_rd_en),
        .core_rd_addr (core_rd_addr),
        .core_rd_data (core_rd_data),
        .core_wr_en   (core_wr_en),
        .core_wr_addr (core_wr_addr),
        .core_wr_data (core_wr_data),
        .core_done    (core_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_overrun  (err_overrun),
        .err_len      (err_len)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference helpers ----------------
    // Lane-word for frame 'kind' at lane-word address 'beat': word k = (kind<<24) | k.
    function automatic logic [DW-1:0] pat_word(input int kind, input int beat);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*WIDTH +: WIDTH] = (32'(kind) << 24) | 32'(beat * LANES + l);
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int j);
        logic [AW-1:0] a, r;
        a = j[AW-1:0];
`ifdef RFFT_BITREV_EN
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
`else
        r = a;
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_frame(input int kind, input int last_beat);
        for (int b = 0; b <= last_beat; b++) begin
            in_valid = 1'b1;
            in_addr  = AW'(b);
            in_data  = pat_word(kind, b);
            in_last  = (b == last_beat);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        core_start = 1'b1;
        tick();
        core_start = 1'b0;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    // Collect drained beats with out_ready following rdy_pat (bit = cycle mod 4).
    // Returns early, without accepting, when beat stop_at is presented.
    task automatic drain_collect(input logic [3:0] rdy_pat, input int stop_at);
        int            cyc;
        bit            finished, p_stall;
        logic [DW-1:0] p_data;
        logic [AW-1:0] p_addr;
        logic          p_last;
        cyc = 0; finished = 0; p_stall = 0;
        p_data = '0; p_addr = '0; p_last = 1'b0;
        n_beats = 0; n_last = 0; last_pos = -1; stall_bad = 0; timed_out = 0;
        while (!finished) begin
            if (p_stall && (out_valid !== 1'b1 || out_data !== p_data ||
                            out_addr !== p_addr || out_last !== p_last))
                stall_bad++;
            if (n_beats == stop_at && out_valid === 1'b1) begin
                out_ready = 1'b0;
                finished  = 1;
            end else begin
                out_ready = rdy_pat[cyc[1:0]];
                p_stall   = (out_valid === 1'b1) && !out_ready;
                p_data    = out_data;
                p_addr    = out_addr;
                p_last    = out_last;
                if (out_valid === 1'b1 && out_ready) begin
                    if (n_beats < DEPTH) begin
                        got_addr[n_beats] = out_addr;
                        got_data[n_beats] = out_data;
                    end
                    if (out_last === 1'b1) begin
                        n_last++;
                        if (last_pos < 0) last_pos = n_beats;
                        finished = 1;
                    end
                    n_beats++;
                    if (n_beats >= DEPTH + 8) finished = 1;
                end
                tick();
                cyc++;
                if (cyc > 1000) begin
                    timed_out = 1;
                    finished  = 1;
                end
            end
        end
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready got=%b exp=0", frame_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (err_overrun !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL reset_errs got=%b%b exp=00", err_overrun, err_len); end
        checks++; if (core_rd_data !== '0) begin errors++; $display("FAIL reset_core_rd_data got=%h exp=0", core_rd_data); end
        checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr got=%0d exp=0", out_addr); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_single_frame();
        logic [AW-1:0] a;
        load_frame(0, DEPTH - 1);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL single_frame_ready got=%b exp=1", frame_ready); end
        pulse_start();
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_start got=%b exp=0", frame_ready); end
        pulse_done();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_latency got=%b exp=1", out_valid); end
        checks++; if (out_addr !== exp_addr(0)) begin errors++; $display("FAIL single_first_addr got=%0d exp=%0d", out_addr, exp_addr(0)); end
        drain_collect(4'b1111, -1);
        checks++; if (timed_out || n_beats != DEPTH) begin errors++; $display("FAIL single_beats got=%0d exp=%0d timeout=%0d", n_beats, DEPTH, timed_out); end
        checks++; if (last_pos != DEPTH - 1) begin errors++; $display("FAIL single_last_pos got=%0d exp=%0d", last_pos, DEPTH - 1); end
        for (int j = 0; j < DEPTH; j++) begin
            a = exp_addr(j);
            checks++; if (got_addr[j] !== a) begin errors++; $display("FAIL single_addr[%0d] got=%0d exp=%0d", j, got_addr[j], a); end
            checks++; if (got_data[j] !== pat_word(0, int'(a))) begin errors++; $display("FAIL single_data[%0d] got=%h exp=%h", j, got_data[j], pat_word(0, int'(a))); end
        end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_ready !== 1'b0) begin
            errors++; $display("FAIL single_idle got v=%b ir=%b fr=%b exp 0 1 0", out_valid, in_ready, frame_ready); end
    endtask

    task automatic test_back_to_back();
        load_frame(1, DEPTH - 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_between got=%b exp=1", in_ready); end
        load_frame(2, DEPTH - 1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got=%b exp=0", in_ready); end
        checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_pre got=%b exp=0", err_overrun); end
        in_valid = 1'b1;
        in_addr  = AW'(5);
        in_data  = {DW{1'b1}};
        tick();
        in_valid = 1'b0;
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got=%b exp=1", err_overrun); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL b2b_frame_ready got=%b exp=1", frame_ready); end
    endtask

    task automatic test_core_inplace();
        logic [AW-1:0] a;
        pulse_start();
        core_rd_en   = 1'b1; core_rd_addr = AW'(5);
        core_wr_en   = 1'b1; core_wr_addr = AW'(5); core_wr_data = ~pat_word(1, 5);
        tick();
        core_rd_en = 1'b0; core_wr_en = 1'b0;
        checks++; if (core_rd_data !== pat_word(1, 5)) begin errors++; $display("FAIL core_read_first got=%h exp=%h", core_rd_data, pat_word(1, 5)); end
        for (int k = 0; k < DEPTH; k++) begin
            core_wr_en = 1'b1; core_wr_addr = AW'(k); core_wr_data = ~pat_word(1, k);
            tick();
        end
        core_wr_en = 1'b0;
        core_rd_en = 1'b1; core_rd_addr = AW'(5);
        tick();
        core_rd_en = 1'b0;
        checks++; if (core_rd_data !== ~pat_word(1, 5)) begin errors++; $display("FAIL core_readback got=%h exp=%h", core_rd_data, ~pat_word(1, 5)); end
        tick();
        checks++; if (core_rd_data !== ~pat_word(1, 5)) begin errors++; $display("FAIL core_rd_hold got=%h exp=%h", core_rd_data, ~pat_word(1, 5)); end
        pulse_done();
        drain_collect(4'b1001, -1);
        checks++; if (timed_out || n_beats != DEPTH) begin errors++; $display("FAIL stall_beats got=%0d exp=%0d timeout=%0d", n_beats, DEPTH, timed_out); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got=%0d unstable cycles exp=0", stall_bad); end
        checks++; if (last_pos != DEPTH - 1) begin errors++; $display("FAIL stall_last_pos got=%0d exp=%0d", last_pos, DEPTH - 1); end
        for (int j = 0; j < DEPTH; j++) begin
            a = exp_addr(j);
            checks++; if (got_addr[j] !== a || got_data[j] !== ~pat_word(1, int'(a))) begin
                errors++; $display("FAIL inv_beat[%0d] got a=%0d d=%h exp a=%0d d=%h", j, got_addr[j], got_data[j], a, ~pat_word(1, int'(a))); end
        end
        checks++; if (in_ready !== 1'b1 || frame_ready !== 1'b1) begin
            errors++; $display("FAIL second_bank_pending got ir=%b fr=%b exp 1 1", in_ready, frame_ready); end
        pulse_start();
        pulse_done();
        drain_collect(4'b1111, -1);
        checks++; if (timed_out || n_beats != DEPTH) begin errors++; $display("FAIL frame_b_beats got=%0d exp=%0d", n_beats, DEPTH); end
        for (int j = 0; j < DEPTH; j++) begin
            a = exp_addr(j);
            checks++; if (got_data[j] !== pat_word(2, int'(a))) begin
                errors++; $display("FAIL frame_b_data[%0d] got=%h exp=%h", j, got_data[j], pat_word(2, int'(a))); end
        end
        checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", err_overrun); end
    endtask

    task automatic test_err_len();
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL err_len_pre got=%b exp=0", err_len); end
        load_frame(3, 10);
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL err_len_set got=%b exp=1", err_len); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL err_len_commit got=%b exp=1", frame_ready); end
        pulse_start();
        pulse_done();
        drain_collect(4'b1111, -1);
        checks++; if (timed_out || n_beats != DEPTH || last_pos != DEPTH - 1) begin
            errors++; $display("FAIL err_len_beats got=%0d last=%0d exp=%0d", n_beats, last_pos, DEPTH); end
        for (int j = 0; j < DEPTH; j++) begin
            a = exp_addr(j);
            e = (int'(a) <= 10) ? pat_word(3, int'(a)) : ~pat_word(1, int'(a));
            checks++; if (got_data[j] !== e) begin errors++; $display("FAIL err_len_data[%0d] got=%h exp=%h", j, got_data[j], e); end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [AW-1:0] a;
        load_frame(4, DEPTH - 1);
        pulse_start();
        pulse_done();
        drain_collect(4'b1111, 20);
        checks++; if (n_beats != 20 || out_valid !== 1'b1 || out_addr !== exp_addr(20)) begin
            errors++; $display("FAIL mid_drain_pos got beats=%0d v=%b a=%0d exp 20 1 %0d", n_beats, out_valid, out_addr, exp_addr(20)); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b%b exp=00", out_valid, out_last); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_ready got=%b exp=0", frame_ready); end
        checks++; if (err_overrun !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL rst_mid_errs got=%b%b exp=00", err_overrun, err_len); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_mid_out_data got=%h exp=0", out_data); end
        tick();
        Reset_n = 1'b1;
        tick();
        load_frame(5, DEPTH - 1);
        pulse_start();
        pulse_done();
        drain_collect(4'b1111, -1);
        checks++; if (timed_out || n_beats != DEPTH || last_pos != DEPTH - 1) begin
            errors++; $display("FAIL fresh_beats got=%0d last=%0d exp=%0d", n_beats, last_pos, DEPTH); end
        for (int j = 0; j < DEPTH; j++) begin
            a = exp_addr(j);
            checks++; if (got_addr[j] !== a || got_data[j] !== pat_word(5, int'(a))) begin
                errors++; $display("FAIL fresh_beat[%0d] got a=%0d d=%h exp a=%0d d=%h", j, got_addr[j], got_data[j], a, pat_word(5, int'(a))); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        repeat (3) tick();
        test_reset();
        Reset_n = 1'b1;
        tick();
        test_single_frame();
        test_back_to_back();
        test_core_inplace();
        test_err_len();
        test_reset_mid_drain();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
